// File: rtl/rv_branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating counters plus stored taken targets,
// with a one-entry-per-cycle flush walk that invalidates the whole table.
module rv_branch_predictor #(
    parameter int N_ENTRIES = 16,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            flush,
    output logic            busy
);

    localparam int IDX_BITS = $clog2(N_ENTRIES);
    localparam int TAG_BITS = XLEN - 2 - IDX_BITS;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t                r_state;
    logic [IDX_BITS-1:0]   r_walk;
    logic                  r_busy;
    logic [N_ENTRIES-1:0]  r_valid;
    logic [1:0]            r_ctr    [N_ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [N_ENTRIES];
    logic [XLEN-1:0]       r_target [N_ENTRIES];

    logic [IDX_BITS-1:0]   w_rd_idx;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic                  w_rd_hit;
    logic [IDX_BITS-1:0]   w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    logic                  w_up_hit;
    logic                  w_up_en;
    logic [3:0]            w_unused_lsbs;

    // Address bits [1:0] never select an entry; they are deliberately dropped.
    assign w_unused_lsbs = {pc[1:0], upd_pc[1:0]};

    assign w_rd_idx = pc[IDX_BITS+1:2];
    assign w_rd_tag = pc[XLEN-1:IDX_BITS+2];
    assign w_rd_hit = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);

    assign w_up_idx = upd_pc[IDX_BITS+1:2];
    assign w_up_tag = upd_pc[XLEN-1:IDX_BITS+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // A flush request in the same idle cycle takes precedence and drops the update.
    assign w_up_en = upd_valid && !r_busy && !flush;

    always_comb begin
        pred_taken  = w_rd_hit && r_ctr[w_rd_idx][1] && !r_busy;
        pred_target = pred_taken ? r_target[w_rd_idx] : pc + XLEN'(4);
    end

    assign busy = r_busy;

    // Control state: FSM, walk pointer, valid bits and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_walk  <= '0;
            r_busy  <= 1'b0;
            r_valid <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_ctr[i] <= 2'b00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_state <= S_CLEAR;
                        r_walk  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_valid[r_walk] <= 1'b0;
                    r_walk          <= r_walk + IDX_BITS'(1);
                    if (r_walk == IDX_BITS'(N_ENTRIES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_up_en) begin
                if (w_up_hit) begin
                    if (upd_taken) begin
                        if (r_ctr[w_up_idx] != 2'b11) begin
                            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
                        end
                    end else begin
                        if (r_ctr[w_up_idx] != 2'b00) begin
                            r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
                        end
                    end
                end else if (upd_taken) begin
                    r_valid[w_up_idx] <= 1'b1;
                    r_ctr[w_up_idx]   <= 2'b10;
                end
            end
        end
    end

    // NOTE: tags and targets are plain storage without reset; a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (!rst && w_up_en && upd_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
        end
    end

endmodule
